// File: rtl/preif_stage_pkg.sv
// Shared CPU front-end definitions: reset vector, PREIF state encoding and
// the pipeline exception-flag bundle.
package preif_stage_pkg;

  localparam logic [31:0] PREIF_RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } preif_state_t;

  typedef struct packed {
    logic Interrupt;
    logic AdEL_IF;
    logic TLBRefill_IF;
    logic TLBInvalid_IF;
    logic RI;
    logic Syscall;
    logic Break;
    logic Overflow;
    logic Trap;
    logic AdEL;
    logic AdES;
    logic TLBRefill;
    logic TLBInvalid;
    logic TLBModified;
    logic Refetch;
    logic Eret;
  } ExceptinPipeType;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/preif_stage_if.sv
// Instruction-address request channel between the PREIF stage and the I-cache.
interface preif_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;

  modport master (output req, output addr, input addr_ok);
  modport slave  (input req, input addr, output addr_ok);
endinterface

// File: rtl/preif_stage_npc_sel.sv
// Next-PC priority mux: exception redirect, then held redirect, then ID
// branch/jump, otherwise the sequential PC+4.
module preif_npc_sel (
  input  logic [31:0] pc_i,
  input  logic        exc_redirect_i,
  input  logic [31:0] exc_target_i,
  input  logic        pend_v_i,
  input  logic [31:0] pend_tgt_i,
  input  logic        id_redirect_i,
  input  logic [31:0] id_target_i,
  output logic [31:0] npc_o,
  output logic        redirect_o
);

  logic [31:0] seq_pc;

  assign seq_pc     = pc_i + 32'd4;
  assign redirect_o = exc_redirect_i | pend_v_i | id_redirect_i;

  always_comb begin
    npc_o = seq_pc;
    if (exc_redirect_i) begin
      npc_o = exc_target_i;
    end else if (pend_v_i) begin
      npc_o = pend_tgt_i;
    end else if (id_redirect_i) begin
      npc_o = id_target_i;
    end
  end

endmodule

// File: rtl/preif_stage.sv
// PREIF stage: owns the fetch PC, issues I-cache address requests and hands
// each accepted PC (with fetch-exception flags) to the IF stage register.
module preif_stage
  import preif_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PREIF_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 IF_Wr,
  input  logic                 EXC_Redirect,
  input  logic [31:0]          EXC_Target,
  input  logic                 ID_Redirect,
  input  logic [31:0]          ID_Target,
  preif_stage_if.master        cpu_ibus,
  output logic [31:0]          PREIF_PC,
  output ExceptinPipeType      IFTLB_ExceptType,
  output logic                 PREIF_Kill
);

  preif_state_t state_q;
  logic [31:0]  pc_q;
  logic         pend_v_q;
  logic [31:0]  pend_tgt_q;
  logic         req_q;

  logic         misalign;
  logic         acc;
  logic         advance;
  logic         hold_cap;
  logic [31:0]  npc;
  logic         redirect;

  preif_npc_sel u_npc_sel (
    .pc_i           (pc_q),
    .exc_redirect_i (EXC_Redirect),
    .exc_target_i   (EXC_Target),
    .pend_v_i       (pend_v_q),
    .pend_tgt_i     (pend_tgt_q),
    .id_redirect_i  (ID_Redirect),
    .id_target_i    (ID_Target),
    .npc_o          (npc),
    .redirect_o     (redirect)
  );

  // A misaligned PC never goes to the bus; it is accepted locally so it can
  // carry AdEL_IF down the pipe.
  assign misalign = is_misaligned(pc_q);
  assign acc      = cpu_ibus.addr_ok | misalign;
  assign advance  = IF_Wr & ((state_q == S_REQ & acc) | (state_q == S_HOLD));
  assign hold_cap = ~IF_Wr & ((state_q == S_REQ & acc) | (state_q == S_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      req_q      <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= ~misalign;
        end
        S_REQ: begin
          if (advance) begin
            pc_q     <= npc;
            pend_v_q <= 1'b0;
            req_q    <= ~is_misaligned(npc);
          end else if (acc) begin
            state_q <= S_HOLD;
            req_q   <= 1'b0;
          end else if (redirect) begin
            // Request not yet taken by the cache: retarget in place.
            pc_q  <= npc;
            req_q <= ~is_misaligned(npc);
          end
        end
        S_HOLD: begin
          if (advance) begin
            state_q  <= S_REQ;
            pc_q     <= npc;
            pend_v_q <= 1'b0;
            req_q    <= ~is_misaligned(npc);
          end
        end
        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
        end
      endcase

      // While the accepted entry waits for IF, remember the redirect;
      // exceptions overwrite, ID keeps the older pending target.
      if (hold_cap) begin
        if (EXC_Redirect) begin
          pend_v_q   <= 1'b1;
          pend_tgt_q <= EXC_Target;
        end else if (ID_Redirect && !pend_v_q) begin
          pend_v_q   <= 1'b1;
          pend_tgt_q <= ID_Target;
        end
      end
    end
  end

  assign cpu_ibus.req  = req_q;
  assign cpu_ibus.addr = pc_q;
  assign PREIF_PC      = pc_q;
  assign PREIF_Kill    = advance & redirect;

  always_comb begin
    IFTLB_ExceptType         = '0;
    IFTLB_ExceptType.AdEL_IF = misalign;
  end

endmodule

// File: tb/tb_preif_stage.sv
// Directed bench for preif_stage: a queue-based reference model checked on
// every negative edge plus hand-computed expectations at key points.
module tb_preif_stage;
  import preif_stage_pkg::*;

  logic            clk;
  logic            rst;
  logic            IF_Wr;
  logic            EXC_Redirect;
  logic [31:0]     EXC_Target;
  logic            ID_Redirect;
  logic [31:0]     ID_Target;
  logic [31:0]     PREIF_PC;
  ExceptinPipeType IFTLB_ExceptType;
  logic            PREIF_Kill;

  int total = 0;
  int bad   = 0;

  preif_stage_if ibus ();

  preif_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .IF_Wr            (IF_Wr),
    .EXC_Redirect     (EXC_Redirect),
    .EXC_Target       (EXC_Target),
    .ID_Redirect      (ID_Redirect),
    .ID_Target        (ID_Target),
    .cpu_ibus         (ibus),
    .PREIF_PC         (PREIF_PC),
    .IFTLB_ExceptType (IFTLB_ExceptType),
    .PREIF_Kill       (PREIF_Kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: fetch PC, whether the fetch has started, whether an
  // accepted entry is waiting for IF, and the remembered redirect (0 or 1 entries).
  logic        m_valid = 1'b0;
  logic        m_started;
  logic        m_held;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  always @(negedge clk) begin
    logic mis, acc, take, exp_req, exp_kill;
    logic [31:0] tgt;
    ExceptinPipeType exp_exc;
    mis  = (m_pc[1:0] != 2'b00);
    acc  = m_held || ibus.addr_ok || mis;
    take = m_started && acc && IF_Wr;
    if (EXC_Redirect)            tgt = EXC_Target;
    else if (m_pend.size() != 0) tgt = m_pend[0];
    else if (ID_Redirect)        tgt = ID_Target;
    else                         tgt = m_pc + 32'd4;
    if (m_valid) begin
      exp_req  = m_started && !m_held && !mis;
      exp_kill = take && (EXC_Redirect || ID_Redirect || m_pend.size() != 0);
      exp_exc  = '0;
      exp_exc.AdEL_IF = mis;
      chk("model_req",  32'(ibus.req), 32'(exp_req));
      chk("model_addr", ibus.addr, m_pc);
      chk("model_pc",   PREIF_PC, m_pc);
      chk("model_exc",  32'(IFTLB_ExceptType), 32'(exp_exc));
      chk("model_kill", 32'(PREIF_Kill), 32'(exp_kill));
    end
    if (rst) begin
      m_pc      = 32'hBFC0_0000;
      m_started = 1'b0;
      m_held    = 1'b0;
      m_pend.delete();
      m_valid   = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
    end else if (take) begin
      m_pc   = tgt;
      m_held = 1'b0;
      m_pend.delete();
    end else if (acc) begin
      m_held = 1'b1;
      if (EXC_Redirect) begin
        m_pend.delete();
        m_pend.push_back(EXC_Target);
      end else if (ID_Redirect && m_pend.size() == 0) begin
        m_pend.push_back(ID_Target);
      end
    end else if (EXC_Redirect) begin
      m_pc = EXC_Target;
    end else if (ID_Redirect) begin
      m_pc = ID_Target;
    end
  end

  task automatic drv(input logic ao, input logic wr, input logic exr, input logic [31:0] ext,
                     input logic idr, input logic [31:0] idt);
    ibus.addr_ok = ao;
    IF_Wr        = wr;
    EXC_Redirect = exr;
    EXC_Target   = ext;
    ID_Redirect  = idr;
    ID_Target    = idt;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("rst_req",  32'(ibus.req), 0);
    chk("rst_pc",   PREIF_PC, 32'hBFC0_0000);
    chk("rst_addr", ibus.addr, 32'hBFC0_0000);
    chk("rst_exc",  32'(IFTLB_ExceptType), 0);
    chk("rst_kill", 32'(PREIF_Kill), 0);
    tick();

    // Sequential fetch at full throughput.
    rst = 1'b0;
    drv(1, 1, 0, 0, 0, 0);
    chk("seq_c1_req", 32'(ibus.req), 0);
    tick();
    drv(1, 1, 0, 0, 0, 0);
    chk("seq_c2_req", 32'(ibus.req), 1);
    chk("seq_pc0", PREIF_PC, 32'hBFC0_0000);
    tick();
    drv(1, 1, 0, 0, 0, 0);
    chk("seq_pc1", PREIF_PC, 32'hBFC0_0004);
    tick();

    // Redirect before the cache accepts: retarget without kill.
    drv(0, 1, 0, 0, 1, 32'h8000_0100);
    chk("seq_pc2", PREIF_PC, 32'hBFC0_0008);
    chk("noacc_kill0", 32'(PREIF_Kill), 0);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    chk("noacc_addr", ibus.addr, 32'h8000_0100);
    chk("noacc_req", 32'(ibus.req), 1);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    chk("noacc_kill2", 32'(PREIF_Kill), 0);
    tick();

    // Accept with IF closed, then ID and EXC redirects while holding.
    drv(1, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 1, 32'h8000_0200);
    chk("hold_req", 32'(ibus.req), 0);
    tick();
    drv(0, 0, 1, 32'hBFC0_0380, 0, 0);
    chk("hold_pc", PREIF_PC, 32'h8000_0100);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    chk("hold_kill", 32'(PREIF_Kill), 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("hold_tgt", PREIF_PC, 32'hBFC0_0380);
    chk("hold_tgt_req", 32'(ibus.req), 1);
    tick();

    // EXC and ID together on an advancing cycle: EXC wins.
    drv(1, 1, 1, 32'h8000_0180, 1, 32'h8000_0300);
    chk("both_kill", 32'(PREIF_Kill), 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("both_pc", PREIF_PC, 32'h8000_0180);
    tick();

    // Misaligned target: no request, AdEL_IF, advances without addr_ok.
    drv(0, 0, 0, 0, 1, 32'h8000_0102);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    chk("mis_pc", PREIF_PC, 32'h8000_0102);
    chk("mis_req", 32'(ibus.req), 0);
    chk("mis_adel", 32'(IFTLB_ExceptType.AdEL_IF), 1);
    chk("mis_int", 32'(IFTLB_ExceptType.Interrupt), 0);
    tick();
    drv(0, 0, 0, 0, 1, 32'h8000_0400);
    chk("mis_adv_pc", PREIF_PC, 32'h8000_0106);
    tick();
    drv(0, 1, 0, 0, 0, 0);
    chk("mis_hold_kill", 32'(PREIF_Kill), 1);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    chk("mis_fix_pc", PREIF_PC, 32'h8000_0400);
    chk("mis_fix_adel", 32'(IFTLB_ExceptType.AdEL_IF), 0);
    tick();

    // Reset while holding with a pending redirect.
    drv(1, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 1, 32'h8000_0180, 0, 0);
    tick();
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    drv(0, 1, 0, 0, 0, 0);
    chk("rst2_pc", PREIF_PC, 32'hBFC0_0000);
    chk("rst2_req", 32'(ibus.req), 0);
    chk("rst2_kill", 32'(PREIF_Kill), 0);
    tick();
    drv(1, 1, 0, 0, 0, 0);
    chk("rst2_nopend_kill", 32'(PREIF_Kill), 0);
    tick();
    drv(1, 1, 0, 0, 0, 0);
    chk("rst2_seq_pc", PREIF_PC, 32'hBFC0_0004);
    tick();
    drv(0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
